dmem_responder: RTL and testbench

- Data-memory responder: the slave end of the core's d_mem interface (d_mem_w_addr, d_mem_w_data, d_mem_we, d_mem_oe, d_mem_r_data).
- Word-organised array with zero-cycle read and a one-entry store buffer, so stores commit one cycle after issue.
- Reads are forwarded from the store buffer when the address matches.
- Adds a post-reset zeroing sweep, a valid/ready preload port for the program loader, and sticky fault detection.

---
 rtl/dmem_responder_pkg.sv | 26 ++
 rtl/dmem_responder_if.sv | 34 +++
 rtl/dmem_store_buf.sv | 45 ++++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared state type and address helpers for dmem_responder
//
// Package beta_mem_pkg
//   dmem_state_t : responder FSM states (CLEAR sweep, READY service)
//   WORD_BYTES   : bytes per array word
//   word_idx()   : byte address -> word index (caller truncates to IDX_W)
//   addr_legal() : word aligned and inside the array
package beta_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_t;

  localparam int unsigned WORD_BYTES = 4;

  function automatic logic [31:0] word_idx(input logic [31:0] addr);
    return addr / WORD_BYTES;
  endfunction

  // For a power-of-two array this is the same as requiring addr[31:IDX_W+2] == 0.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned words);
    return ((addr % WORD_BYTES) == 0) && (word_idx(addr) < words);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core data-memory bus between the core and dmem_responder
//
// Interface dmem_if
//   d_mem_w_addr [31:0] byte address for loads and stores
//   d_mem_w_data [31:0] store data
//   d_mem_we            store strobe
//   d_mem_oe            load strobe
//   d_mem_r_data [31:0] load data, combinational from the responder
// Modports: master (core side), slave (memory side).
interface dmem_if;

  logic [31:0] d_mem_w_addr;
  logic [31:0] d_mem_w_data;
  logic        d_mem_we;
  logic        d_mem_oe;
  logic [31:0] d_mem_r_data;

  modport master (
    output d_mem_w_addr,
    output d_mem_w_data,
    output d_mem_we,
    output d_mem_oe,
    input  d_mem_r_data
  );

  modport slave (
    input  d_mem_w_addr,
    input  d_mem_w_data,
    input  d_mem_we,
    input  d_mem_oe,
    output d_mem_r_data
  );

endinterface

// File: rtl/dmem_store_buf.sv
// rtl/dmem_store_buf.sv - one-entry store buffer with load forwarding for dmem_responder
//
// Ports
//   clk, rst             clock, asynchronous active-high reset (drops the pending entry)
//   cap_en               capture {cap_idx, cap_data} at this edge
//   rd_idx, arr_data     load index and the array word at that index
//   pend_valid/idx/data  pending entry, committed by the parent on the next edge
//   fwd_data             arr_data, or the pending data when the indices match
module dmem_store_buf #(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic [IDX_W-1:0] cap_idx,
  input  logic [31:0]      cap_data,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [31:0]      arr_data,
  output logic             pend_valid,
  output logic [IDX_W-1:0] pend_idx,
  output logic [31:0]      pend_data,
  output logic [31:0]      fwd_data
);

  // The entry lives exactly one cycle unless refilled; the parent commits
  // the old entry on the same edge a new one is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      pend_data  <= '0;
    end else begin
      pend_valid <= cap_en;
      if (cap_en) begin
        pend_idx  <= cap_idx;
        pend_data <= cap_data;
      end
    end
  end

  // Only the already-captured entry forwards, so a load issued alongside a
  // store sees the pre-store value.
  assign fwd_data = (pend_valid && (pend_idx == rd_idx)) ? pend_data : arr_data;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word array, store buffer, zeroing sweep, preload, fault
//
// Optional feature macro: DMEM_ACCESS_COUNT_EN (adds load_count / store_count)
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   bus              dmem_if.slave core load/store port
//   busy             high while the post-reset zeroing sweep runs
//   ld_valid/ready   program-loader preload handshake
//   ld_addr, ld_data preload word index and data
//   fault            sticky illegal-access flag
//   fault_clr        synchronous clear of fault
//   load_count       legal loads served (DMEM_ACCESS_COUNT_EN, saturating)
//   store_count      legal stores accepted (DMEM_ACCESS_COUNT_EN, saturating)
module dmem_responder
  import beta_mem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  dmem_if.slave            bus,
  output logic             busy,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [IDX_W-1:0] ld_addr,
  input  logic [31:0]      ld_data,
  output logic             fault,
  input  logic             fault_clr
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0]      load_count,
  output logic [31:0]      store_count
`endif
);

  dmem_state_t      state;
  logic [IDX_W-1:0] sweep_cnt;
  logic [31:0]      mem [MEM_WORDS];

  logic             in_clear;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_legal;
  logic             st_cap;
  logic             fault_ev;
  logic             pend_valid;
  logic [IDX_W-1:0] pend_idx;
  logic [31:0]      pend_data;
  logic [31:0]      fwd_data;

  assign in_clear  = (state == CLEAR);
  assign acc_idx   = IDX_W'(word_idx(bus.d_mem_w_addr));
  assign acc_legal = addr_legal(bus.d_mem_w_addr, MEM_WORDS);

  // Core strobes are ignored entirely during the sweep.
  assign st_cap   = !in_clear && bus.d_mem_we && acc_legal;
  assign fault_ev = !in_clear && (bus.d_mem_we || bus.d_mem_oe) && !acc_legal;

  // Holding preload off while a store is pending keeps the single array
  // write port free of real conflicts.
  assign ld_ready = !in_clear && !pend_valid;

  assign bus.d_mem_r_data = (!in_clear && acc_legal) ? fwd_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      sweep_cnt <= '0;
      busy      <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == IDX_W'(MEM_WORDS - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          busy <= 1'b0;
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Contents are deliberately not reset; the sweep zeroes them.
  always_ff @(posedge clk) begin
    if (in_clear) begin
      mem[sweep_cnt] <= '0;
    end else if (pend_valid) begin
      mem[pend_idx] <= pend_data;
    end else if (ld_valid && ld_ready) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // A new fault in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (fault_ev) begin
      fault <= 1'b1;
    end else if (fault_clr) begin
      fault <= 1'b0;
    end
  end

  dmem_store_buf #(
    .IDX_W(IDX_W)
  ) u_store_buf (
    .clk       (clk),
    .rst       (rst),
    .cap_en    (st_cap),
    .cap_idx   (acc_idx),
    .cap_data  (bus.d_mem_w_data),
    .rd_idx    (acc_idx),
    .arr_data  (mem[acc_idx]),
    .pend_valid(pend_valid),
    .pend_idx  (pend_idx),
    .pend_data (pend_data),
    .fwd_data  (fwd_data)
  );

`ifdef DMEM_ACCESS_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_count  <= '0;
      store_count <= '0;
    end else begin
      if (!in_clear && bus.d_mem_oe && acc_legal && (load_count != '1)) begin
        load_count <= load_count + 32'd1;
      end
      if (st_cap && (store_count != '1)) begin
        store_count <= store_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        fault;
  logic        fault_clr = 1'b0;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] load_count;
  logic [31:0] store_count;
`endif

  dmem_if bus ();

  dmem_responder #(
    .MEM_WORDS(WORDS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .fault    (fault),
    .fault_clr(fault_clr)
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    .load_count (load_count),
    .store_count(store_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural memory as seen by the next cycle's loads.
  logic [31:0] m_mem [WORDS];
  bit          m_fault;
  bit          m_prev_store;
  int unsigned m_loads;
  int unsigned m_stores;

  logic        c_we, c_oe, c_ldv, c_fclr;
  logic [31:0] c_addr, c_wdata, c_ld_data;
  logic [9:0]  c_ld_addr;
  logic [31:0] exp_rdata;
  logic        exp_ready;

  function automatic bit legal(input logic [31:0] a);
    return ((a % 4) == 0) && (a < 32'(4 * WORDS));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < WORDS; i++) m_mem[i] = 32'h0;
    m_fault      = 1'b0;
    m_prev_store = 1'b0;
    m_loads      = 0;
    m_stores     = 0;
  endtask

  // Called just after an active edge; leaves time at the falling edge.
  task automatic drive(input logic we, input logic oe, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic ldv, input logic [9:0] la,
                       input logic [31:0] ld, input logic fclr);
    logic [31:0] a;
    c_we = we; c_oe = oe; c_addr = addr; c_wdata = wdata;
    c_ldv = ldv; c_ld_addr = la; c_ld_data = ld; c_fclr = fclr;
    bus.d_mem_we = we; bus.d_mem_oe = oe;
    bus.d_mem_w_addr = addr; bus.d_mem_w_data = wdata;
    ld_valid = ldv; ld_addr = la; ld_data = ld; fault_clr = fclr;
    a = addr;
    exp_rdata = legal(addr) ? m_mem[a[11:2]] : 32'h0;
    exp_ready = !m_prev_store;
    #4;
  endtask

  task automatic tick();
    bit ok;
    logic [31:0] a;
    ok = legal(c_addr);
    a  = c_addr;
    if (c_ldv && exp_ready) m_mem[c_ld_addr] = c_ld_data;
    if (c_we && ok) m_mem[a[11:2]] = c_wdata;
    if ((c_we || c_oe) && !ok) m_fault = 1'b1;
    else if (c_fclr) m_fault = 1'b0;
    m_prev_store = c_we && ok;
    if (c_oe && ok) m_loads++;
    if (c_we && ok) m_stores++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    bus.d_mem_we = 1'b0; bus.d_mem_oe = 1'b0;
    bus.d_mem_w_addr = '0; bus.d_mem_w_data = '0;
    ld_valid = 1'b0; fault_clr = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", busy); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    n_cmp++; if (bus.d_mem_r_data !== 32'h0) begin n_bad++; $display("FAIL reset_r_data: got %h want 0", bus.d_mem_r_data); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", fault); end
`ifdef DMEM_ACCESS_COUNT_EN
    n_cmp++; if (load_count !== 32'h0 || store_count !== 32'h0) begin
      n_bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", load_count, store_count);
    end
`endif
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
      // Stray strobes during the sweep must be ignored.
      if (n == 10) begin
        bus.d_mem_we = 1'b1; bus.d_mem_oe = 1'b1; bus.d_mem_w_addr = 32'h1001;
      end else if (n == 11) begin
        bus.d_mem_oe = 1'b0; bus.d_mem_w_addr = 32'h4; bus.d_mem_w_data = 32'hFFFF_FFFF;
      end else if (n == 12) begin
        bus.d_mem_we = 1'b0; bus.d_mem_oe = 1'b1; bus.d_mem_w_addr = 32'h0;
        #1;
        n_cmp++; if (bus.d_mem_r_data !== 32'h0) begin n_bad++; $display("FAIL sweep_r_data: got %h want 0", bus.d_mem_r_data); end
      end else if (n == 13) begin
        bus.d_mem_oe = 1'b0;
      end
    end
    n_cmp++; if (n != WORDS) begin n_bad++; $display("FAIL sweep_len: got %0d cycles want %0d", n, WORDS); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL sweep_fault: got %b want 0", fault); end
  endtask

  task automatic test_store_load();
    drive(1, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0);
    tick();
    drive(0, 1, 32'h10, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.d_mem_r_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL fwd_load: got %h want deadbeef", bus.d_mem_r_data); end
    tick();
    drive(0, 1, 32'h10, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.d_mem_r_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL array_load: got %h want deadbeef", bus.d_mem_r_data); end
    tick();
    // Store and load together: load sees the old word.
    drive(1, 1, 32'h10, 32'h1111_1111, 0, 0, 0, 0);
    n_cmp++; if (bus.d_mem_r_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL same_cycle_ld_st: got %h want deadbeef", bus.d_mem_r_data); end
    tick();
    drive(0, 1, 32'h10, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.d_mem_r_data !== 32'h1111_1111) begin n_bad++; $display("FAIL after_ld_st: got %h want 11111111", bus.d_mem_r_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] want_d [5];
    logic        want_r [5];
    logic [31:0] addrs  [5];
    logic [31:0] data   [5];
    logic        wes    [5];
    addrs = '{32'h20, 32'h20, 32'h24, 32'h20, 32'h24};
    data  = '{32'h1, 32'h2, 32'h3, 32'h0, 32'h0};
    wes   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    want_d = '{32'h0, 32'h1, 32'h0, 32'h2, 32'h3};
    want_r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      drive(wes[k], 1, addrs[k], data[k], 0, 0, 0, 0);
      n_cmp++; if (bus.d_mem_r_data !== want_d[k]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", k, bus.d_mem_r_data, want_d[k]); end
      n_cmp++; if (ld_ready !== want_r[k]) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, ld_ready, want_r[k]); end
      tick();
    end
  endtask

  task automatic test_fault();
    drive(0, 1, 32'h13, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.d_mem_r_data !== 32'h0) begin n_bad++; $display("FAIL bad_load_data: got %h want 0", bus.d_mem_r_data); end
    tick();
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL fault_set: got %b want 1", fault); end
    drive(1, 0, 32'h1000, 32'h5555_5555, 0, 0, 0, 0);
    tick();
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL fault_sticky: got %b want 1", fault); end
    drive(0, 1, 32'h0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.d_mem_r_data !== 32'h0) begin n_bad++; $display("FAIL bad_store_dropped: got %h want 0", bus.d_mem_r_data); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL fault_clr: got %b want 0", fault); end
    drive(0, 1, 32'h2, 0, 0, 0, 0, 1);
    tick();
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL fault_clr_vs_event: got %b want 1", fault); end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    n_cmp++; if (fault !== m_fault) begin n_bad++; $display("FAIL fault_reclr: got %b want %b", fault, m_fault); end
  endtask

  task automatic test_preload();
    int first_ready;
    first_ready = -1;
    for (int k = 0; k < 8 && first_ready < 0; k++) begin
      drive(k < 4, 0, 32'h40 + 32'(4 * k), 32'h100 + 32'(k), k >= 1, 10'd5, 32'hA5A5_A5A5, 0);
      n_cmp++; if (ld_ready !== exp_ready) begin n_bad++; $display("FAIL preload_ready[%0d]: got %b want %b", k, ld_ready, exp_ready); end
      if (k >= 1 && ld_ready === 1'b1) first_ready = k;
      tick();
    end
    n_cmp++; if (first_ready != 5) begin n_bad++; $display("FAIL preload_accept_cycle: got %0d want 5", first_ready); end
    drive(0, 1, 32'h14, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.d_mem_r_data !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL preload_data: got %h want a5a5a5a5", bus.d_mem_r_data); end
    tick();
    drive(1, 0, 32'h18, 32'h7777_7777, 1, 10'd6, 32'h9999_9999, 0);
    n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL same_idx_ready: got %b want 1", ld_ready); end
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 32'h18, 0, 0, 0, 0, 0);
      n_cmp++; if (bus.d_mem_r_data !== 32'h7777_7777) begin n_bad++; $display("FAIL store_wins[%0d]: got %h want 77777777", k, bus.d_mem_r_data); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int r;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'h1000 + ($urandom & 32'h7FFF_FFFF);
      else a = 32'($urandom_range(0, 31)) * 4;
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a, $urandom,
            $urandom_range(0, 2) == 0, 10'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 9) == 0);
      n_cmp++; if (bus.d_mem_r_data !== exp_rdata) begin n_bad++; $display("FAIL rand_data[%0d]: addr %h got %h want %h", k, a, bus.d_mem_r_data, exp_rdata); end
      n_cmp++; if (ld_ready !== exp_ready) begin n_bad++; $display("FAIL rand_ready[%0d]: got %b want %b", k, ld_ready, exp_ready); end
      tick();
      n_cmp++; if (fault !== m_fault) begin n_bad++; $display("FAIL rand_fault[%0d]: got %b want %b", k, fault, m_fault); end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_counters();
`ifdef DMEM_ACCESS_COUNT_EN
    int unsigned l0;
    int unsigned s0;
    n_cmp++; if (load_count !== 32'(m_loads) || store_count !== 32'(m_stores)) begin
      n_bad++; $display("FAIL count_totals: got %0d/%0d want %0d/%0d", load_count, store_count, m_loads, m_stores);
    end
    l0 = m_loads;
    s0 = m_stores;
    drive(0, 1, 32'h0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 32'h8, 32'h1, 0, 0, 0, 0); tick();
    drive(0, 1, 32'h4, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 32'hC, 32'h2, 0, 0, 0, 0); tick();
    drive(0, 1, 32'h3, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 32'h8, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
    n_cmp++; if (load_count !== 32'(l0 + 3)) begin n_bad++; $display("FAIL load_count: got %0d want %0d", load_count, l0 + 3); end
    n_cmp++; if (store_count !== 32'(s0 + 2)) begin n_bad++; $display("FAIL store_count: got %0d want %0d", store_count, s0 + 2); end
`endif
  endtask

  task automatic test_sweep();
    logic [31:0] a;
    for (int k = 0; k < 40; k++) begin
      a = 32'($urandom_range(0, WORDS - 1)) * 4;
      drive(1, 0, a, $urandom | 32'h1, 1, 10'($urandom_range(0, WORDS - 1)), 32'hFFFF_0000, 0);
      tick();
    end
    // Reset lands with a store still pending.
    test_reset();
    for (int i = 0; i < WORDS; i++) begin
      drive(0, 1, 32'(i) * 4, 0, 0, 0, 0, 0);
      n_cmp++; if (bus.d_mem_r_data !== 32'h0) begin n_bad++; $display("FAIL sweep_word[%0d]: got %h want 0", i, bus.d_mem_r_data); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_fault();
    test_preload();
    test_random();
    test_counters();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
